// File: rtl/out_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : out_port_arbiter
// Purpose  : Round-robin arbiter that shares one output-port write bus
//            (write / address / data_out) among NREQ requesters. At most one
//            port write is issued per cycle. Addresses below PORT_BASE are
//            rejected with an err pulse, so only the PORT_BASE..8'hFF window
//            ever reaches the port flip-flops.
//
// Ports    : clk       - system clock, all state on posedge
//            reset     - asynchronous active-low reset
//            req       - per-requester write request, held until ack/err
//            req_addr  - packed addresses, requester i at [8i+7:8i]
//            req_data  - packed write data, same packing
//            req_lock  - per-requester bus lock request (ARB_LOCK_EN only)
//            ack       - one-cycle pulse, write issued for that requester
//            err       - one-cycle pulse, request rejected (illegal address)
//            write     - registered port write strobe
//            address   - registered port address
//            data_out  - registered port write data
//            grant_id  - registered index of the last granted requester
//
// Options  : define ARB_LOCK_EN to add req_lock, the LOCK_MAX parameter and
//            the IDLE/LOCKED bus-lock FSM. Without it the arbiter is pure
//            round-robin.
//
// Revision : 1.0 - initial release
// ============================================================================
module out_port_arbiter #(
  parameter int         NREQ      = 4,
  parameter logic [7:0] PORT_BASE = 8'hF0
`ifdef ARB_LOCK_EN
  ,
  parameter int         LOCK_MAX  = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] req_addr,
  input  logic [NREQ*8-1:0] req_data,
`ifdef ARB_LOCK_EN
  input  logic [NREQ-1:0]   req_lock,
`endif
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   err,
  output logic              write,
  output logic [7:0]        address,
  output logic [7:0]        data_out,
  output logic [2:0]        grant_id
);

  // Registered outputs and round-robin pointer
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] err_q, err_d;
  logic            write_q, write_d;
  logic [7:0]      address_q, address_d;
  logic [7:0]      data_q, data_d;
  logic [2:0]      grant_q, grant_d;
  logic [2:0]      ptr_q, ptr_d;

  // Arbitration results
  logic [NREQ-1:0] elig;
  logic            found;
  logic [2:0]      win;
  logic [7:0]      sel_addr;
  logic [7:0]      sel_data;
  logic            legal;

`ifdef ARB_LOCK_EN
  localparam int CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

  lock_state_t      state_q, state_d;
  logic [2:0]       owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]  owner_mask;
  logic             lock_exit;
  logic             lock_hold;

  assign owner_mask = NREQ'(1) << owner_q;

  // The exit decision is made at the same edge as arbitration: when the
  // owner drops its lock or the hold limit is reached, that edge already
  // arbitrates round-robin. The pointer equals the owner throughout the
  // lock, so round-robin naturally resumes from the owner.
  assign lock_exit = (state_q == ST_LOCKED) &&
                     (((req_lock & owner_mask) == '0) ||
                      (cnt_q == CNT_W'(LOCK_MAX - 1)));
  assign lock_hold = (state_q == ST_LOCKED) && !lock_exit;
`endif

  // A requester whose ack/err pulse is currently visible is masked so the
  // same transfer is never issued twice while it reacts to the pulse.
  always_comb begin
    elig = req & ~(ack_q | err_q);
`ifdef ARB_LOCK_EN
    if (lock_hold) begin
      elig = elig & owner_mask;
    end
`endif
  end

  // Round-robin pick: the eligible requester with the smallest distance
  // from ptr+1 (mod NREQ) wins.
  always_comb begin
    int d;
    int best_d;
    found  = 1'b0;
    win    = '0;
    best_d = NREQ;
    d      = 0;
    for (int i = 0; i < NREQ; i++) begin
      d = (i + NREQ - 1 - int'(ptr_q)) % NREQ;
      if (elig[i] && (d < best_d)) begin
        best_d = d;
        win    = 3'(i);
        found  = 1'b1;
      end
    end
  end

  // Winner's address/data mux
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == 3'(i)) begin
        sel_addr = req_addr[i*8 +: 8];
        sel_data = req_data[i*8 +: 8];
      end
    end
  end

  assign legal = (sel_addr >= PORT_BASE);

  // Next-state for the bus registers and the pointer
  always_comb begin
    ack_d     = '0;
    err_d     = '0;
    write_d   = 1'b0;
    address_d = address_q;
    data_d    = data_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    if (found) begin
      ptr_d   = win;
      grant_d = win;
      if (legal) begin
        write_d   = 1'b1;
        address_d = sel_addr;
        data_d    = sel_data;
        ack_d     = NREQ'(1) << win;
      end else begin
        // Rejected: bus address/data keep their previous values
        err_d = NREQ'(1) << win;
      end
    end
  end

`ifdef ARB_LOCK_EN
  // Lock FSM next-state. Only a legal grant whose requester asks for the
  // lock can enter LOCKED; a rejected grant never locks the bus.
  always_comb begin
    state_d = ST_IDLE;
    owner_d = owner_q;
    cnt_d   = '0;
    if (lock_hold) begin
      state_d = ST_LOCKED;
      cnt_d   = cnt_q + CNT_W'(1);
    end else if (found && legal &&
                 ((req_lock & (NREQ'(1) << win)) != '0)) begin
      state_d = ST_LOCKED;
      owner_d = win;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_q     <= '0;
      err_q     <= '0;
      write_q   <= 1'b0;
      address_q <= '0;
      data_q    <= '0;
      grant_q   <= '0;
      ptr_q     <= 3'(NREQ - 1);
    end else begin
      ack_q     <= ack_d;
      err_q     <= err_d;
      write_q   <= write_d;
      address_q <= address_d;
      data_q    <= data_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
    end
  end

  assign ack      = ack_q;
  assign err      = err_q;
  assign write    = write_q;
  assign address  = address_q;
  assign data_out = data_q;
  assign grant_id = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_out_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_out_port_arbiter
// Purpose  : Self-checking bench for out_port_arbiter (NREQ=4, PORT_BASE=F0).
//            A vector table drives per-cycle requests; each vector's expected
//            bus state is queued when driven and popped after the edge.
//            Hand sequences cover async reset mid-stream and, when
//            ARB_LOCK_EN is defined, the bus-lock hold/release cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_out_port_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_addr;
  logic [31:0] req_data;
`ifdef ARB_LOCK_EN
  logic [3:0]  req_lock;
`endif
  logic [3:0]  ack;
  logic [3:0]  err;
  logic        write;
  logic [7:0]  address;
  logic [7:0]  data_out;
  logic [2:0]  grant_id;

  int n_tests = 0;
  int n_fail  = 0;

  out_port_arbiter #(
    .NREQ      (4),
    .PORT_BASE (8'hF0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
`ifdef ARB_LOCK_EN
    .req_lock (req_lock),
`endif
    .ack      (ack),
    .err      (err),
    .write    (write),
    .address  (address),
    .data_out (data_out),
    .grant_id (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] ack;
    logic [3:0] err;
    logic       wr;
    logic [7:0] adr;
    logic [7:0] dat;
    logic [2:0] gid;
  } exp_t;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] addr;
    logic [31:0] data;
    exp_t        e;
  } vec_t;

  exp_t sb_q[$];
  vec_t vt[14];

  function automatic vec_t mk(logic [3:0] r, logic [31:0] a, logic [31:0] d,
                              logic [3:0] ak, logic [3:0] er, logic w,
                              logic [7:0] ad, logic [7:0] dt, logic [2:0] g);
    vec_t v;
    v.req   = r;
    v.addr  = a;
    v.data  = d;
    v.e.ack = ak;
    v.e.err = er;
    v.e.wr  = w;
    v.e.adr = ad;
    v.e.dat = dt;
    v.e.gid = g;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_bus(string tag, exp_t e);
    chk({tag, " write"},    32'(write),    32'(e.wr));
    chk({tag, " address"},  32'(address),  32'(e.adr));
    chk({tag, " data_out"}, 32'(data_out), 32'(e.dat));
    chk({tag, " ack"},      32'(ack),      32'(e.ack));
    chk({tag, " err"},      32'(err),      32'(e.err));
    chk({tag, " grant_id"}, 32'(grant_id), 32'(e.gid));
  endtask

  // Drive one vector at the falling edge, queue its expectation, and check
  // the registered result just after the following rising edge.
  task automatic apply(string tag, vec_t v);
    exp_t e;
    @(negedge clk);
    req      = v.req;
    req_addr = v.addr;
    req_data = v.data;
    sb_q.push_back(v.e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      chk_bus(tag, e);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
`ifdef ARB_LOCK_EN
    req_lock = '0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    exp_t z;
    vec_t v;
    reset    = 1'b0;
    req      = '0;
    req_addr = '0;
    req_data = '0;
`ifdef ARB_LOCK_EN
    req_lock = '0;
`endif

    // req, addr{3,2,1,0}, data{3,2,1,0} -> ack, err, write, address, data, gid
    vt[0]  = mk(4'b0001, 32'h000000F3, 32'h0000005A, 4'b0001, 4'b0000, 1'b1, 8'hF3, 8'h5A, 3'd0);
    vt[1]  = mk(4'b0001, 32'h000000F3, 32'h0000005A, 4'b0000, 4'b0000, 1'b0, 8'hF3, 8'h5A, 3'd0);
    vt[2]  = mk(4'b0000, 32'h000000F3, 32'h0000005A, 4'b0000, 4'b0000, 1'b0, 8'hF3, 8'h5A, 3'd0);
    vt[3]  = mk(4'b1111, 32'hF3F2F1F0, 32'h13121110, 4'b0010, 4'b0000, 1'b1, 8'hF1, 8'h11, 3'd1);
    vt[4]  = mk(4'b1111, 32'hF3F2F1F0, 32'h13122110, 4'b0100, 4'b0000, 1'b1, 8'hF2, 8'h12, 3'd2);
    vt[5]  = mk(4'b1111, 32'hF3F2F1F0, 32'h13222110, 4'b1000, 4'b0000, 1'b1, 8'hF3, 8'h13, 3'd3);
    vt[6]  = mk(4'b1111, 32'hF3F2F1F0, 32'h23222110, 4'b0001, 4'b0000, 1'b1, 8'hF0, 8'h10, 3'd0);
    vt[7]  = mk(4'b1111, 32'hF3F2F1F0, 32'h23222120, 4'b0010, 4'b0000, 1'b1, 8'hF1, 8'h21, 3'd1);
    vt[8]  = mk(4'b0001, 32'h0000007F, 32'h00000099, 4'b0000, 4'b0001, 1'b0, 8'hF1, 8'h21, 3'd0);
    vt[9]  = mk(4'b0110, 32'h00F6F500, 32'h00323100, 4'b0010, 4'b0000, 1'b1, 8'hF5, 8'h31, 3'd1);
    vt[10] = mk(4'b0100, 32'h00F6F500, 32'h00323100, 4'b0100, 4'b0000, 1'b1, 8'hF6, 8'h32, 3'd2);
    vt[11] = mk(4'b0000, 32'h00F6F500, 32'h00323100, 4'b0000, 4'b0000, 1'b0, 8'hF6, 8'h32, 3'd2);
    vt[12] = mk(4'b1000, 32'hEF000000, 32'h44000000, 4'b0000, 4'b1000, 1'b0, 8'hF6, 8'h32, 3'd3);
    vt[13] = mk(4'b0000, 32'hEF000000, 32'h44000000, 4'b0000, 4'b0000, 1'b0, 8'hF6, 8'h32, 3'd3);

    // Reset state before any edge with reset released
    do_reset();
    #1;
    z = '{ack: 4'b0, err: 4'b0, wr: 1'b0, adr: 8'h00, dat: 8'h00, gid: 3'd0};
    chk_bus("reset", z);

    for (int i = 0; i < 14; i++) begin
      apply($sformatf("vec%0d", i), vt[i]);
    end

    // Async reset while write is high
    v = mk(4'b0001, 32'h000000F3, 32'h0000005A, 4'b0001, 4'b0000, 1'b1, 8'hF3, 8'h5A, 3'd0);
    apply("pre_rst", v);
    #1;
    reset = 1'b0;
    req   = '0;
    #1;
    chk_bus("async_rst", z);
    @(negedge clk);
    reset = 1'b1;
    v = mk(4'b0100, 32'h00F80000, 32'h00770000, 4'b0100, 4'b0000, 1'b1, 8'hF8, 8'h77, 3'd2);
    apply("post_rst", v);

`ifdef ARB_LOCK_EN
    // Requester 1 holds the lock; 0 and 2 wait until the forced release
    do_reset();
    for (int e = 0; e <= 16; e++) begin
      logic [3:0] xa;
      @(negedge clk);
      req      = (e == 0) ? 4'b0010 : 4'b0111;
      req_lock = 4'b0010;
      req_addr = 32'hF3F2F1F0;
      req_data = 32'h33221100;
      @(posedge clk);
      #1;
      xa = (e == 16) ? 4'b0100 : ((e % 2 == 0) ? 4'b0010 : 4'b0000);
      chk($sformatf("lockA e%0d ack", e), 32'(ack), 32'(xa));
    end

    // Requester 3 drops its lock after three writes; requester 0 wins next
    do_reset();
    for (int e = 0; e <= 5; e++) begin
      logic [3:0] xa;
      @(negedge clk);
      req      = (e == 0) ? 4'b1000 : 4'b1001;
      req_lock = (e == 5) ? 4'b0000 : 4'b1000;
      req_addr = 32'hF3F2F1F0;
      req_data = 32'h33221100;
      @(posedge clk);
      #1;
      xa = (e == 5) ? 4'b0001 : ((e % 2 == 0) ? 4'b1000 : 4'b0000);
      chk($sformatf("lockB e%0d ack", e), 32'(ack), 32'(xa));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/out_port_arbiter.md
Name: out_port_arbiter

Overview:
- Shares the single output-port write bus (write / address / data) among NREQ requesters, e.g. the CPU store path, a DMA engine and a timer/event unit.
- Round-robin arbitration with registered bus outputs; at most one port write per cycle.
- Per-requester ack/err pulses.
- Rejects addresses outside the 16-port output window so that only 0xF0..0xFF ever reach the port flip-flops.

Parameters:
- NREQ, 4, number of requesters (2..8).
- PORT_BASE, 8'hF0, lowest legal output-port address; legal window is PORT_BASE..8'hFF.
- LOCK_MAX, 16, maximum cycles a lock may be held before forced release (LOCK_EN only).

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester write request; held with addr/data until ack or err.
- req_addr  in  NREQ*8  packed addresses; requester i at [8i+7:8i].
- req_data  in  NREQ*8  packed write data, same packing.
- req_lock  in  NREQ  lock request (present only with LOCK_EN).
- ack  out  NREQ  one-cycle pulse: write issued for that requester.
- err  out  NREQ  one-cycle pulse: request rejected (address below PORT_BASE).
- write  out  1  port write strobe, registered.
- address  out  8  port address, registered.
- data_out  out  8  port write data, registered.
- grant_id  out  3  index of the last granted requester, registered.

Behaviour:
- Reset (reset=0, async): ack, err, write, address, data_out = 0; grant_id = 0.
  - Internal rr pointer = NREQ-1, so requester 0 has first priority.
  - Lock state = IDLE, lock counter = 0.
  - Any pending request is dropped; requesters still asserting req re-arbitrate on the first edge after release.
- Eligible set at edge E: req[i]=1 AND (ack[i]|err[i])=0.
  - This mask prevents double-issue while the requester reacts to its pulse.
- Winner: first eligible index scanning ptr+1, ptr+2, ... modulo NREQ.
  - ptr <= winner on every grant, legal or rejected.
  - No eligible requester: ptr unchanged, write=0, all ack/err=0.
- Legal grant (req_addr >= PORT_BASE), registered at edge E:
  - write=1, address=req_addr[w], data_out=req_data[w], ack[w]=1, grant_id=w.
  - Latency: request sampled at E, bus strobe and ack both visible in the cycle after E.
- Illegal grant: write=0, address/data_out hold previous values, err[w]=1, grant_id=w.
- write, ack and err deassert the cycle after a grant unless a new grant occurs at that edge.
- Throughput:
  - Single requester: one write per 2 cycles (masked on its ack cycle).
  - Two or more busy requesters: one write per cycle, interleaved.
- Requester contract: addr/data stable from req rise until ack/err seen; a new transfer may follow immediately.
- Simultaneous ack of requester i and new req from requester j at the same edge: j arbitrates normally.

Optional Feature:
- Macro ARB_LOCK_EN.
- Defined: req_lock port exists. Two-state FSM, IDLE and LOCKED.
  - IDLE -> LOCKED when the legal winner w has req_lock[w]=1; owner=w, counter=0.
  - In LOCKED: only the owner is eligible (ack masking still applies); counter increments each cycle.
  - LOCKED -> IDLE when req_lock[owner]=0 at an edge, or counter reaches LOCK_MAX-1 (forced release).
  - On exit, round-robin resumes from ptr=owner.
  - An illegal-address grant never enters LOCKED.
- Not defined: req_lock port absent, no FSM; behaviour is pure round-robin as above.

Test Plan:
- Reset release, req=4'b0001, addr0=F3, data0=5A -> next cycle write=1, address=F3, data_out=5A, ack=0001, grant_id=0; following cycle write=0.
- req=4'b1111, all addresses legal, held continuously with new data after each ack -> grant order 0,1,2,3,0,... with one write per cycle and no requester acked on consecutive cycles.
- req=4'b0001 with addr0=7F -> err=0001 one cycle, write stays 0, address unchanged; next grant goes to the next eligible requester in round-robin order.
- reset pulled low mid-stream while write=1 -> write, ack, address immediately 0; after release with req=4'b0100 -> requester 2 granted first.
- ARB_LOCK_EN: requester 1 holds req_lock=1 while requesters 0 and 2 request -> only requester 1 is acked, for 16 cycles; then forced release and requester 2 is granted next.
- ARB_LOCK_EN: requester 3 drops req_lock after 3 writes -> next edge returns to IDLE and requester 0 wins.
